// File: rtl/counter_credit_sched.sv
// Round-robin consume/return arbiter in front of a shared up/down credit counter.
// Define COUNTER_CREDIT_SCHED_STARVE_EN to add starvation counters with a consume priority lock.
module counter_credit_sched #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 4,
    parameter int AMT_W        = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         cfg_init_value,
    input  logic                     cfg_reinit,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*AMT_W-1:0] req_amt,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       ret_valid,
    input  logic [NUM_REQ*AMT_W-1:0] ret_amt,
    output logic [NUM_REQ-1:0]       ret_ready,
    input  logic [WIDTH-1:0]         cnt_value,
    output logic                     cnt_reinit,
    output logic [WIDTH-1:0]         cnt_initial_value,
    output logic                     cnt_incr_valid,
    output logic [AMT_W-1:0]         cnt_incr,
    output logic                     cnt_decr_valid,
    output logic [AMT_W-1:0]         cnt_decr,
    output logic                     init_busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SW    = WIDTH + 1;
    localparam logic [WIDTH:0] CMAX = SW'((1 << WIDTH) - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || AMT_W > WIDTH || STARVE_LIMIT < 1) begin : g_param_check
        $error("counter_credit_sched: unsupported parameter set");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state;

    logic [PTR_W-1:0]   req_ptr, ret_ptr, req_win, ret_win;
    logic [PTR_W:0]     req_pick, ret_pick;
    logic [NUM_REQ-1:0] req_elig, ret_elig, req_mask;
    logic               grant_en;

    // Handshake: a transfer happens when valid && ready in the same cycle; ready is
    // combinational from this cycle's valid/amt/cnt_value and denied clients just wait.
    assign grant_en          = (state == ST_RUN) && !cfg_reinit;
    assign cnt_initial_value = cfg_init_value;

    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [PTR_W-1:0]   ptr);
        rr_pick = '0;
        // Walk backwards so the last hit is the nearest client at or after ptr.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (elig[idx]) rr_pick = {1'b1, PTR_W'(idx)};
        end
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_elig[i] = grant_en && req_valid[i] &&
                          (SW'(req_amt[i*AMT_W +: AMT_W]) <= {1'b0, cnt_value});
            ret_elig[i] = grant_en && ret_valid[i] &&
                          (({1'b0, cnt_value} + SW'(ret_amt[i*AMT_W +: AMT_W])) <= CMAX);
        end
    end

`ifdef COUNTER_CREDIT_SCHED_STARVE_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0]  starve_cnt [NUM_REQ];
    logic             lock_any;
    logic [PTR_W-1:0] lock_idx;

    always_comb begin
        lock_any = 1'b0;
        lock_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && starve_cnt[i] == SC_W'(STARVE_LIMIT)) begin
                lock_any = 1'b1;
                lock_idx = PTR_W'(i);
            end
        end
        req_mask = lock_any ? (NUM_REQ'(1) << lock_idx) : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state == ST_INIT || !req_valid[i] || req_ready[i])
                    starve_cnt[i] <= '0;
                else if (starve_cnt[i] != SC_W'(STARVE_LIMIT))
                    starve_cnt[i] <= starve_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign req_mask = '1;
`endif

    assign req_pick = rr_pick(req_elig & req_mask, req_ptr);
    assign ret_pick = rr_pick(ret_elig, ret_ptr);
    assign req_win  = req_pick[PTR_W-1:0];
    assign ret_win  = ret_pick[PTR_W-1:0];

    always_comb begin
        req_ready      = '0;
        ret_ready      = '0;
        cnt_decr_valid = 1'b0;
        cnt_decr       = '0;
        cnt_incr_valid = 1'b0;
        cnt_incr       = '0;
        if (req_pick[PTR_W]) begin
            req_ready[req_win] = 1'b1;
            cnt_decr_valid     = 1'b1;
            cnt_decr           = req_amt[int'(req_win)*AMT_W +: AMT_W];
        end
        if (ret_pick[PTR_W]) begin
            ret_ready[ret_win] = 1'b1;
            cnt_incr_valid     = 1'b1;
            cnt_incr           = ret_amt[int'(ret_win)*AMT_W +: AMT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            cnt_reinit <= 1'b1;
            init_busy  <= 1'b1;
            req_ptr    <= '0;
            ret_ptr    <= '0;
        end else begin
            if (state == ST_INIT) begin
                state      <= ST_RUN;
                cnt_reinit <= 1'b0;
                init_busy  <= 1'b0;
            end else if (cfg_reinit) begin
                state      <= ST_INIT;
                cnt_reinit <= 1'b1;
                init_busy  <= 1'b1;
            end
            if (req_pick[PTR_W])
                req_ptr <= (req_win == PTR_W'(NUM_REQ - 1)) ? '0 : req_win + 1'b1;
            if (ret_pick[PTR_W])
                ret_ptr <= (ret_win == PTR_W'(NUM_REQ - 1)) ? '0 : ret_win + 1'b1;
        end
    end
endmodule

// File: tb/tb_counter_credit_sched.sv
// Bench for counter_credit_sched: behavioural counter + scheduler model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_counter_credit_sched;
    localparam int NUM_REQ = 4;
    localparam int WIDTH = 4;
    localparam int AMT_W = 2;
    localparam int STARVE_LIMIT = 7;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [WIDTH-1:0] cfg_init_value = '0;
    logic cfg_reinit = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0, ret_valid = '0;
    logic [NUM_REQ*AMT_W-1:0] req_amt = '0, ret_amt = '0;
    logic [NUM_REQ-1:0] req_ready, ret_ready;
    logic [WIDTH-1:0] cnt_value = '0;
    logic cnt_reinit, cnt_incr_valid, cnt_decr_valid, init_busy;
    logic [WIDTH-1:0] cnt_initial_value;
    logic [AMT_W-1:0] cnt_incr, cnt_decr;

    int checks = 0;
    int failures = 0;
    logic done = 1'b0;

    counter_credit_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .AMT_W(AMT_W),
                           .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_init_value(cfg_init_value), .cfg_reinit(cfg_reinit),
        .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
        .ret_valid(ret_valid), .ret_amt(ret_amt), .ret_ready(ret_ready),
        .cnt_value(cnt_value), .cnt_reinit(cnt_reinit), .cnt_initial_value(cnt_initial_value),
        .cnt_incr_valid(cnt_incr_valid), .cnt_incr(cnt_incr),
        .cnt_decr_valid(cnt_decr_valid), .cnt_decr(cnt_decr), .init_busy(init_busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // counter instance stand-in, driven by the DUT
    always @(posedge clk) begin
        if (cnt_reinit) cnt_value <= cnt_initial_value;
        else cnt_value <= cnt_value + (cnt_incr_valid ? {2'b00, cnt_incr} : 4'd0)
                                    - (cnt_decr_valid ? {2'b00, cnt_decr} : 4'd0);
    end

    // reference model: own credit value, pointers and init flag
    logic m_init = 1'b1;
    int m_val = 0;
    int m_cptr = 0, m_rptr = 0;
    int m_starve [NUM_REQ];
    int lock_id, c_best, r_best, c_win, r_win, a, d;
    logic [NUM_REQ-1:0] e_req, e_ret;
    logic e_dv, e_iv;
    logic [AMT_W-1:0] e_d, e_i;

    always_comb begin
        e_req = '0; e_ret = '0; e_dv = 1'b0; e_iv = 1'b0; e_d = '0; e_i = '0;
        lock_id = -1; c_best = NUM_REQ; r_best = NUM_REQ; c_win = 0; r_win = 0; a = 0; d = 0;
`ifdef COUNTER_CREDIT_SCHED_STARVE_EN
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[i] && m_starve[i] >= STARVE_LIMIT) lock_id = i;
`endif
        if (!m_init && !cfg_reinit) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                a = int'(req_amt[i*AMT_W +: AMT_W]);
                d = (i - m_cptr + NUM_REQ) % NUM_REQ;
                if (req_valid[i] && a <= m_val && (lock_id < 0 || lock_id == i) && d < c_best) begin
                    c_best = d; c_win = i; e_d = AMT_W'(a);
                end
                a = int'(ret_amt[i*AMT_W +: AMT_W]);
                d = (i - m_rptr + NUM_REQ) % NUM_REQ;
                if (ret_valid[i] && m_val + a <= CMAX && d < r_best) begin
                    r_best = d; r_win = i; e_i = AMT_W'(a);
                end
            end
            e_dv = (c_best < NUM_REQ);
            e_iv = (r_best < NUM_REQ);
            if (e_dv) e_req[c_win] = 1'b1;
            if (e_iv) e_ret[r_win] = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init <= 1'b1; m_cptr <= 0; m_rptr <= 0;
            for (int i = 0; i < NUM_REQ; i++) m_starve[i] <= 0;
        end else begin
            if (m_init) m_init <= 1'b0;
            else if (cfg_reinit) m_init <= 1'b1;
            if (e_dv) m_cptr <= (c_win + 1) % NUM_REQ;
            if (e_iv) m_rptr <= (r_win + 1) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_init || !req_valid[i] || e_req[i]) m_starve[i] <= 0;
                else if (m_starve[i] < STARVE_LIMIT) m_starve[i] <= m_starve[i] + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (m_init) m_val <= int'(cfg_init_value);
        else m_val <= m_val + (e_iv ? int'(e_i) : 0) - (e_dv ? int'(e_d) : 0);
    end

    // scoreboard: per-cycle compare against the model
    initial begin
        while (!done) begin
            @(negedge clk); #2;
            checks++;
            if ({req_ready, ret_ready, cnt_decr_valid, cnt_decr, cnt_incr_valid, cnt_incr, cnt_reinit, init_busy}
                !== {e_req, e_ret, e_dv, e_d, e_iv, e_i, m_init, m_init}) begin
                failures++;
                $display("FAIL outputs t=%0t: got rdy=%b/%b dec=%b/%0d inc=%b/%0d reinit=%b busy=%b expected rdy=%b/%b dec=%b/%0d inc=%b/%0d reinit=%b busy=%b",
                         $time, req_ready, ret_ready, cnt_decr_valid, cnt_decr, cnt_incr_valid, cnt_incr,
                         cnt_reinit, init_busy, e_req, e_ret, e_dv, e_d, e_iv, e_i, m_init, m_init);
            end
            checks++;
            if (cnt_value !== WIDTH'(m_val)) begin
                failures++;
                $display("FAIL value t=%0t: got %0d expected %0d", $time, cnt_value, m_val);
            end
            checks++;
            if (cnt_initial_value !== cfg_init_value) begin
                failures++;
                $display("FAIL init_value t=%0t: got %0d expected %0d", $time, cnt_initial_value, cfg_init_value);
            end
        end
    end

    // driver tasks
    task automatic step(input logic [3:0] rv, input logic [7:0] ra, input logic [3:0] tv,
                        input logic [7:0] ta, input logic ri, input logic [3:0] iv);
        @(negedge clk);
        req_valid = rv; req_amt = ra; ret_valid = tv; ret_amt = ta;
        cfg_reinit = ri; cfg_init_value = iv;
        #3;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic reinit_to(input logic [3:0] v);
        step(4'h0, 8'h00, 4'h0, 8'h00, 1'b1, v);
        step(4'h0, 8'h00, 4'h0, 8'h00, 1'b0, v);
    endtask

    int exp_rdy [7] = '{1, 2, 4, 8, 1, 0, 0};
    int exp_val [7] = '{5, 4, 3, 2, 1, 0, 0};

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) step(4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 4'd5);
        lit("rst_reinit", cnt_reinit, 1);
        lit("rst_busy", init_busy, 1);
        lit("rst_ready", req_ready, 0);
        @(negedge clk); rst_n = 1'b1; #3;
        lit("init_reinit", cnt_reinit, 1);
        lit("init_busy", init_busy, 1);

        // all four clients consume 1 from value 5
        for (int k = 0; k < 7; k++) begin
            step(4'hF, 8'h55, 4'h0, 8'h00, 1'b0, 4'd5);
            lit("rr_busy", init_busy, 0);
            lit("rr_grant", req_ready, exp_rdy[k]);
            lit("rr_value", cnt_value, exp_val[k]);
        end

        // reinit to 9 with requests pending; pointers must survive
        step(4'hF, 8'h55, 4'h1, 8'h01, 1'b1, 4'd9);
        lit("pulse_req", req_ready, 0);
        lit("pulse_ret", ret_ready, 0);
        step(4'hF, 8'h55, 4'h1, 8'h01, 1'b0, 4'd9);
        lit("reinit_init", cnt_reinit, 1);
        lit("reinit_req", req_ready, 0);
        step(4'hF, 8'h55, 4'h1, 8'h01, 1'b0, 4'd9);
        lit("reinit_value", cnt_value, 9);
        lit("reinit_req_ptr", req_ready, 2);
        lit("reinit_ret", ret_ready, 1);

        // value 1: client0 wants 2, client1 wants 1
        reinit_to(4'd1);
        step(4'b0011, 8'b0000_0110, 4'h0, 8'h00, 1'b0, 4'd1);
        lit("amt_value", cnt_value, 1);
        lit("amt_grant", req_ready, 2);
        lit("amt_decr", cnt_decr, 1);
        step(4'b0011, 8'b0000_0110, 4'h0, 8'h00, 1'b0, 4'd1);
        lit("empty_grant", req_ready, 0);
        lit("empty_value", cnt_value, 0);

        // near CMAX: return 3 at 14 must wait for the consume
        reinit_to(4'd14);
        step(4'b0001, 8'h02, 4'b0100, 8'h30, 1'b0, 4'd14);
        lit("ovf_value", cnt_value, 14);
        lit("ovf_req", req_ready, 1);
        lit("ovf_ret", ret_ready, 0);
        step(4'b0000, 8'h00, 4'b0100, 8'h30, 1'b0, 4'd14);
        lit("ret_value", cnt_value, 12);
        lit("ret_grant", ret_ready, 4);
        lit("ret_incr", cnt_incr, 3);
        step(4'b1000, 8'h00, 4'b1000, 8'h00, 1'b0, 4'd14);
        lit("max_value", cnt_value, 15);
        lit("zero_req", req_ready, 8);
        lit("zero_ret", ret_ready, 8);
        lit("zero_dv", cnt_decr_valid, 1);
        lit("zero_iv", cnt_incr_valid, 1);
        step(4'b0000, 8'h00, 4'b0010, 8'h04, 1'b0, 4'd14);
        lit("full_ret", ret_ready, 0);

        // client0 wants 3 while others churn amt 1 at value 2
        reinit_to(4'd2);
        for (int k = 0; k < 10; k++) begin
            step(4'hF, 8'h57, 4'b1110, 8'h54, 1'b0, 4'd2);
`ifdef COUNTER_CREDIT_SCHED_STARVE_EN
            if (k == 7) begin
                lit("lock_req", req_ready, 0);
                lit("lock_value", cnt_value, 2);
            end
            if (k == 8) begin
                lit("lock_grant", req_ready, 1);
                lit("lock_value3", cnt_value, 3);
            end
`else
            if (k == 0) begin
                lit("churn_req", req_ready, 2);
                lit("churn_value", cnt_value, 2);
            end
`endif
        end

        step(4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 4'd2);
        done = 1'b1;
        @(negedge clk); #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
